// File: rtl/ym_bus_master.sv
// Z80-side I/O bus master for a dual YM/AY sound chip pair.
// Queues register requests and expands each into SEL / ADDR / DATA I/O cycles.
module ym_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter bit FM_EN      = 1'b1
) (
    input  logic        clkcpu,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_chip,
    input  logic        req_rd,
    input  logic [7:0]  req_reg,
    input  logic [7:0]  req_val,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic        busy,
    output logic [15:0] a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    output logic        n_iorq,
    output logic        n_rd,
    output logic        n_wr,
    output logic        n_m1,
    input  logic        n_wait
);
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} busState_e;
    typedef enum logic [1:0] {P_SEL, P_ADDR, P_DATA} phase_e;
    typedef struct packed {
        logic       chip;
        logic       rd;
        logic [7:0] regNum;
        logic [7:0] val;
    } request_t;

    request_t      fifoMem [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [PW:0]   count_q, count_d;
    busState_e     state_q, state_d;
    phase_e        phase_q, phase_d;
    request_t      cur_q, cur_d, head;
    logic          cacheValid_q, cacheValid_d;
    logic          cacheChip_q, cacheChip_d;
    logic          push, pop, startReq;
    logic          curIsRead, nextIsRead;
    logic [15:0]   nextAddr;
    logic [7:0]    nextData;

    logic          req_ready_q, busy_q, rvalid_q, d_oe_q;
    logic          n_iorq_q, n_rd_q, n_wr_q;
    logic [7:0]    rdata_q, d_out_q;
    logic [15:0]   a_q;

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign a         = a_q;
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;
    assign n_iorq    = n_iorq_q;
    assign n_rd      = n_rd_q;
    assign n_wr      = n_wr_q;
    assign n_m1      = 1'b1;

    // Sequencer next state; a new request may start from IDLE or straight out of a DATA T3.
    always_comb begin
        push         = req_valid && req_ready_q;
        head         = fifoMem[rdPtr_q];
        pop          = 1'b0;
        startReq     = 1'b0;
        state_d      = state_q;
        phase_d      = phase_q;
        cur_d        = cur_q;
        cacheValid_d = cacheValid_q;
        cacheChip_d  = cacheChip_q;
        case (state_q)
            S_IDLE: startReq = (count_q != '0);
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_TW;
            S_TW:   if (n_wait) state_d = S_T3;
            S_T3: begin
                if (phase_q != P_DATA) begin
                    phase_d = (phase_q == P_SEL) ? P_ADDR : P_DATA;
                    state_d = S_T1;
                end else if (count_q != '0) begin
                    startReq = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (startReq) begin
            pop     = 1'b1;
            cur_d   = head;
            state_d = S_T1;
            if (cacheValid_q && (cacheChip_q == head.chip)) begin
                phase_d = P_ADDR;
            end else begin
                phase_d      = P_SEL;
                cacheValid_d = 1'b1;
                cacheChip_d  = head.chip;
            end
        end
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        curIsRead  = (phase_q == P_DATA) && cur_q.rd;
        nextIsRead = (phase_d == P_DATA) && cur_d.rd;
        nextAddr   = (phase_d == P_DATA && !cur_d.rd) ? 16'hBFFD : 16'hFFFD;
        nextData   = cur_d.val;
        case (phase_d)
            P_SEL:   nextData = {5'b11111, ~FM_EN, 1'b1, ~cur_d.chip};
            P_ADDR:  nextData = cur_d.regNum;
            default: nextData = cur_d.val;
        endcase
    end

    always_ff @(posedge clkcpu) begin
        if (push) fifoMem[wrPtr_q] <= {req_chip, req_rd, req_reg, req_val};
    end

    // Bus outputs are set up on entry to each state and simply held through TW stalls.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= P_SEL;
            cur_q        <= '0;
            cacheValid_q <= 1'b0;
            cacheChip_q  <= 1'b0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            a_q          <= 16'hFFFF;
            d_out_q      <= '0;
            d_oe_q       <= 1'b0;
            n_iorq_q     <= 1'b1;
            n_rd_q       <= 1'b1;
            n_wr_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cur_q        <= cur_d;
            cacheValid_q <= cacheValid_d;
            cacheChip_q  <= cacheChip_d;
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
            count_q      <= count_d;
            req_ready_q  <= (count_d != FULL_COUNT);
            busy_q       <= (count_d != '0) || (state_d != S_IDLE);
            rvalid_q     <= 1'b0;
            if (state_q == S_T3 && curIsRead) begin
                rdata_q  <= d_in;
                rvalid_q <= 1'b1;
            end
            case (state_d)
                S_IDLE: begin
                    a_q      <= 16'hFFFF;
                    d_oe_q   <= 1'b0;
                    n_iorq_q <= 1'b1;
                    n_rd_q   <= 1'b1;
                    n_wr_q   <= 1'b1;
                end
                S_T1: begin
                    a_q      <= nextAddr;
                    d_out_q  <= nextData;
                    d_oe_q   <= !nextIsRead;
                    n_iorq_q <= 1'b1;
                    n_rd_q   <= 1'b1;
                    n_wr_q   <= 1'b1;
                end
                S_T2: begin
                    n_iorq_q <= 1'b0;
                    n_rd_q   <= !curIsRead;
                    n_wr_q   <= curIsRead;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ym_bus_master.sv
// Scoreboard bench for ym_bus_master: directed requests queue expected bus cycles,
// negedge monitors pop and compare each completed I/O cycle and each rvalid pulse.
module tb_ym_bus_master;
    logic        clkcpu, rst_n;
    logic        req_valid, req_ready, req_chip, req_rd;
    logic [7:0]  req_reg, req_val, rdata, d_out, d_in;
    logic        rvalid, busy, d_oe, n_iorq, n_rd, n_wr, n_m1, n_wait;
    logic [15:0] a;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        isRead;
        int          lowLen;
    } busExp_t;

    typedef struct {
        logic       chip;
        logic [7:0] regNum;
        logic [7:0] val;
        logic       sel;
        logic       ready;
    } burst_t;

    busExp_t     expBus[$];
    logic [7:0]  expRead[$];
    int          checks = 0;
    int          passes = 0;

    ym_bus_master #(.FIFO_DEPTH(4), .FM_EN(1'b1)) dut (
        .clkcpu(clkcpu), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip), .req_rd(req_rd),
        .req_reg(req_reg), .req_val(req_val), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .a(a), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
        .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1), .n_wait(n_wait)
    );

    initial clkcpu = 1'b0;
    always #5 clkcpu = ~clkcpu;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic pushExpect(input logic chip, input logic rd, input logic [7:0] regNum, input logic [7:0] val,
                              input logic expSel, input logic expData, input int addrLen, input int dataLen,
                              input logic [7:0] rdExp);
        busExp_t e;
        if (expSel) begin
            e.addr = 16'hFFFD; e.data = chip ? 8'hFA : 8'hFB; e.isRead = 1'b0; e.lowLen = 3;
            expBus.push_back(e);
        end
        e.addr = 16'hFFFD; e.data = regNum; e.isRead = 1'b0; e.lowLen = addrLen;
        expBus.push_back(e);
        if (expData) begin
            e.addr = rd ? 16'hFFFD : 16'hBFFD; e.data = val; e.isRead = rd; e.lowLen = dataLen;
            expBus.push_back(e);
            if (rd) expRead.push_back(rdExp);
        end
    endtask

    // Called at a negedge; holds the request until accepted, then returns at the following negedge.
    task automatic applyStimulus(input logic chip, input logic rd, input logic [7:0] regNum, input logic [7:0] val,
                                 input logic expSel, input logic expData, input int addrLen, input int dataLen,
                                 input logic [7:0] rdExp);
        int waitCnt = 0;
        req_valid = 1'b1; req_chip = chip; req_rd = rd; req_reg = regNum; req_val = val;
        while (!req_ready && waitCnt < 300) begin
            @(negedge clkcpu);
            waitCnt++;
        end
        if (!req_ready) begin
            checkOutput("req_accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
        end else begin
            pushExpect(chip, rd, regNum, val, expSel, expData, addrLen, dataLen, rdExp);
            @(posedge clkcpu);
            @(negedge clkcpu);
            req_valid = 1'b0;
        end
    endtask

    task automatic waitIdle(input string name, input int expCycles);
        int cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            @(negedge clkcpu);
        end
        if (busy) checkOutput({name, "_timeout"}, {31'd0, busy}, 32'd0);
        else if (expCycles != 0) checkOutput(name, cnt, expCycles);
    endtask

    task automatic waitBusLow(input logic [15:0] addr, input logic wantRead);
        int cnt = 0;
        while (!(!n_iorq && a == addr && n_rd == !wantRead) && cnt < 400) begin
            @(negedge clkcpu);
            cnt++;
        end
        if (cnt >= 400) checkOutput("strobe_wait_timeout", {31'd0, n_iorq}, 32'd0);
    endtask

    // Bus cycle monitor: one scoreboard entry per strobe-low window.
    logic        inCycle = 1'b0, stableOk, capNwr, capNrd, capOe;
    int          lowCnt = 0;
    logic [15:0] capA;
    logic [7:0]  capD;
    busExp_t     monE;
    always @(negedge clkcpu) begin
        if (!rst_n) begin
            inCycle = 1'b0;
            lowCnt  = 0;
        end else if (!n_iorq) begin
            if (!inCycle) begin
                inCycle = 1'b1; lowCnt = 1; stableOk = 1'b1;
                capA = a; capD = d_out; capNwr = n_wr; capNrd = n_rd; capOe = d_oe;
            end else begin
                lowCnt++;
                if (a != capA || d_out != capD || n_wr != capNwr || n_rd != capNrd || d_oe != capOe)
                    stableOk = 1'b0;
            end
        end else if (inCycle) begin
            inCycle = 1'b0;
            if (expBus.size() == 0) begin
                checkOutput("bus_unexpected_cycle", {16'd0, capA}, 32'hFFFFFFFF);
            end else begin
                monE = expBus.pop_front();
                checkOutput("bus_addr", {16'd0, capA}, {16'd0, monE.addr});
                checkOutput("bus_n_rd", {31'd0, capNrd}, {31'd0, !monE.isRead});
                checkOutput("bus_n_wr", {31'd0, capNwr}, {31'd0, monE.isRead});
                checkOutput("bus_d_oe", {31'd0, capOe}, {31'd0, !monE.isRead});
                if (!monE.isRead) checkOutput("bus_data", {24'd0, capD}, {24'd0, monE.data});
                if (monE.lowLen != 0) checkOutput("bus_strobe_len", lowCnt, monE.lowLen);
                checkOutput("bus_stable", {31'd0, stableOk}, 32'd1);
                if (monE.isRead) checkOutput("rvalid_after_read", {31'd0, rvalid}, 32'd1);
            end
        end
    end

    logic rvalidPrev = 1'b0;
    always @(negedge clkcpu) begin
        if (!rst_n) begin
            rvalidPrev = 1'b0;
        end else begin
            if (rvalid) begin
                checkOutput("rvalid_pulse", {31'd0, rvalidPrev}, 32'd0);
                if (expRead.size() == 0) checkOutput("rdata_unexpected", {24'd0, rdata}, 32'hFFFFFFFF);
                else checkOutput("rdata", {24'd0, rdata}, {24'd0, expRead.pop_front()});
            end
            rvalidPrev = rvalid;
        end
    end

    burst_t burst[6];

    initial begin
        int drainCnt;
        burst[0] = '{1'b0, 8'h10, 8'h11, 1'b1, 1'b1};
        burst[1] = '{1'b0, 8'h11, 8'h22, 1'b0, 1'b1};
        burst[2] = '{1'b1, 8'h12, 8'h33, 1'b1, 1'b1};
        burst[3] = '{1'b1, 8'h13, 8'h44, 1'b0, 1'b1};
        burst[4] = '{1'b0, 8'h14, 8'h55, 1'b1, 1'b0};
        burst[5] = '{1'b0, 8'h15, 8'h66, 1'b0, 1'b0};

        rst_n = 1'b1; req_valid = 1'b0; req_chip = 1'b0; req_rd = 1'b0;
        req_reg = 8'h00; req_val = 8'h00; d_in = 8'h5A; n_wait = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clkcpu);
        checkOutput("reset_n_iorq", {31'd0, n_iorq}, 32'd1);
        checkOutput("reset_n_rd", {31'd0, n_rd}, 32'd1);
        checkOutput("reset_n_wr", {31'd0, n_wr}, 32'd1);
        checkOutput("reset_d_oe", {31'd0, d_oe}, 32'd0);
        checkOutput("reset_a", {16'd0, a}, 32'hFFFF);
        checkOutput("reset_d_out", {24'd0, d_out}, 32'h00);
        checkOutput("reset_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("n_m1_const", {31'd0, n_m1}, 32'd1);
        rst_n = 1'b1;
        @(negedge clkcpu);
        checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);

        $display("[TB] first write with SEL");
        applyStimulus(1'b0, 1'b0, 8'h07, 8'h38, 1'b1, 1'b1, 3, 3, 8'h00);
        waitIdle("busy_len_sel", 13);
        checkOutput("idle_a", {16'd0, a}, 32'hFFFF);
        checkOutput("idle_d_oe", {31'd0, d_oe}, 32'd0);

        $display("[TB] cached chip, SEL skipped");
        applyStimulus(1'b0, 1'b0, 8'h08, 8'h0F, 1'b0, 1'b1, 3, 3, 8'h00);
        waitIdle("busy_len_nosel", 9);

        $display("[TB] read from chip 1");
        applyStimulus(1'b1, 1'b1, 8'h0E, 8'h00, 1'b1, 1'b1, 3, 3, 8'hA5);
        waitBusLow(16'hFFFD, 1'b1);
        repeat (2) @(negedge clkcpu);
        d_in = 8'hA5;
        @(negedge clkcpu);
        d_in = 8'h5A;
        waitIdle("busy_read", 0);
        checkOutput("rdata_hold", {24'd0, rdata}, 32'hA5);

        $display("[TB] wait states on a write");
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h77, 1'b0, 1'b1, 3, 8, 8'h00);
        waitBusLow(16'hBFFD, 1'b0);
        @(negedge clkcpu);
        n_wait = 1'b0;
        repeat (5) @(negedge clkcpu);
        n_wait = 1'b1;
        waitIdle("busy_wait", 0);

        $display("[TB] fill FIFO while the bus is stalled");
        n_wait = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h02, 1'b0, 1'b1, 0, 3, 8'h00);
        @(negedge clkcpu);
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_chip = burst[i].chip; req_rd = 1'b0;
            req_reg = burst[i].regNum; req_val = burst[i].val;
            checkOutput("ready_burst", {31'd0, req_ready}, {31'd0, burst[i].ready});
            if (burst[i].ready)
                pushExpect(burst[i].chip, 1'b0, burst[i].regNum, burst[i].val, burst[i].sel, 1'b1, 3, 3, 8'h00);
            @(posedge clkcpu);
            @(negedge clkcpu);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clkcpu);
        checkOutput("ready_full_stall", {31'd0, req_ready}, 32'd0);
        checkOutput("busy_full_stall", {31'd0, busy}, 32'd1);
        n_wait = 1'b1;
        for (int i = 4; i < 6; i++)
            applyStimulus(burst[i].chip, 1'b0, burst[i].regNum, burst[i].val, burst[i].sel, 1'b1, 3, 3, 8'h00);
        waitIdle("busy_burst", 0);

        $display("[TB] reset during DATA T2");
        applyStimulus(1'b0, 1'b0, 8'h30, 8'h99, 1'b0, 1'b0, 3, 3, 8'h00);
        waitBusLow(16'hBFFD, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_n_iorq", {31'd0, n_iorq}, 32'd1);
        checkOutput("abort_n_wr", {31'd0, n_wr}, 32'd1);
        checkOutput("abort_d_oe", {31'd0, d_oe}, 32'd0);
        checkOutput("abort_a", {16'd0, a}, 32'hFFFF);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("abort_rdata", {24'd0, rdata}, 32'h00);
        repeat (3) @(negedge clkcpu);
        rst_n = 1'b1;
        @(negedge clkcpu);
        checkOutput("ready_after_abort", {31'd0, req_ready}, 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h07, 8'h38, 1'b1, 1'b1, 3, 3, 8'h00);
        waitIdle("busy_after_abort", 13);

        drainCnt = 0;
        while (expBus.size() != 0 && drainCnt < 100) begin
            @(negedge clkcpu);
            drainCnt++;
        end
        checkOutput("scoreboard_drained", expBus.size(), 32'd0);
        checkOutput("read_queue_drained", expRead.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ym_bus_master.md
YM_BUS_MASTER -- requirements
Module: ym_bus_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered register requests (power of two, min 2).
REQ-002 Parameter FM_EN, default 1, FM-part enable; it sets select-byte bit 2.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clkcpu  input  1  clock for all state; all outputs are registered on its rising edge.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  request accepted on the same edge as req_valid=1 (FIFO not full).
REQ-007 req_chip  input  1  target chip: 0 = YM1, 1 = YM2.
REQ-008 req_rd  input  1  1 = register read, 0 = register write.
REQ-009 req_reg  input  8  register number.
REQ-010 req_val  input  8  write value (ignored for reads).
REQ-011 rdata  output  8  register read result.
REQ-012 rvalid  output  1  one-cycle pulse; rdata is valid while it is high.
REQ-013 busy  output  1  high while the FIFO is non-empty or a bus cycle is in progress.
REQ-014 a  output  16  Z80 address bus.
REQ-015 d_out  output  8  data driven on the bus.
REQ-016 d_oe  output  1  d_out drive enable.
REQ-017 d_in  input  8  bus data in.
REQ-018 n_iorq, n_rd, n_wr  output  1 each  Z80 strobes, active-low.
REQ-019 n_m1  output  1  constant 1.
REQ-020 n_wait  input  1  wait request, active-low.

Function
REQ-021 The block SHALL accept requests into a FIFO_DEPTH-entry FIFO. A push SHALL occur only when req_valid=1 and the FIFO is not full, evaluated before any same-cycle pop.
REQ-022 Each request SHALL expand into the following bus-cycle sequence:
- SEL: write 0xFFFD with data {5'b11111, ~FM_EN, 1'b1, ~chip}.
- ADDR: write 0xFFFD with data = reg.
- DATA: for a write, write 0xBFFD with data = val; for a read, read 0xFFFD.
REQ-023 SEL SHALL be skipped when the cached chip selection is valid and equals req_chip. Each SEL SHALL update the cache and mark it valid.
REQ-024 Each bus cycle SHALL follow states T1 -> T2 -> TW -> T3, one clkcpu each; the first T1 SHALL start on the cycle after the FIFO pop.
- T1: a is valid, all strobes high, d_oe = 1 for writes.
- T2 to T3: n_iorq = 0, plus n_wr = 0 (write) or n_rd = 0 (read).
REQ-025 In TW, if n_wait=0 at the clock edge, the block SHALL remain in TW with all outputs held.
REQ-026 For reads, d_in SHALL be captured into rdata at the edge ending T3, and rvalid SHALL pulse in the following cycle.
REQ-027 After T3, strobes SHALL return high. d_oe SHALL drop to 0 on the same edge unless the next state is a write T1.
REQ-028 The next bus cycle, or the next request's first T1, SHALL follow T3 with no idle cycle. Minimum cost per request: 8 clocks without SEL, 12 clocks with SEL.
REQ-029 busy SHALL be 1 from the edge that accepts a push until the end of the last T3 with the FIFO empty.
REQ-030 FIFO full: req_ready = 0. FIFO empty: the sequencer SHALL stay IDLE with a = 0xFFFF and d_oe = 0.

Reset
REQ-031 On rst_n=0 the following SHALL apply asynchronously:
- n_iorq = n_rd = n_wr = 1, d_oe = 0.
- a = 0xFFFF, d_out = 0x00.
- rvalid = 0, rdata = 0x00, busy = 0.
- req_ready = 0 while rst_n = 0.
- FIFO emptied, chip cache invalid, sequencer IDLE.
REQ-032 A reset during any bus-cycle state SHALL abort it; the interrupted request SHALL be discarded.
REQ-033 After release, req_ready SHALL be 1 on the first clkcpu edge.

Verification
REQ-034 Write chip0, reg 0x07, val 0x38 after reset -> three write cycles: 0xFFFD/0xFB, 0xFFFD/0x07, 0xBFFD/0x38. Strobes low 3 clocks each; 12 clocks total.
REQ-035 Second write chip0, reg 0x08, val 0x0F -> SEL skipped: 0xFFFD/0x08, 0xBFFD/0x0F; 8 clocks.
REQ-036 Read chip1, reg 0x0E, d_in = 0xA5 during the read T3 -> SEL data 0xFA. Then 0xFFFD/0x0E write, 0xFFFD read. rdata = 0xA5 with a one-cycle rvalid.
REQ-037 n_wait held low 5 clocks in the TW of a write -> TW lasts 6 clocks, strobes low 8 clocks, data and address stable throughout.
REQ-038 Push 6 back-to-back with FIFO_DEPTH=4 while the bus is stalled -> req_ready = 0 after the 4th accept. All accepted requests are issued in order and no entry is lost or duplicated.
REQ-039 Assert rst_n=0 during a DATA-cycle T2 -> strobes high and d_oe = 0 immediately. After release, the next chip0 write emits a SEL cycle (cache invalidated).
